hamming_secded_engine: RTL
==========================

Name: hamming_secded_engine

Overview:
- Memory-mastering SECDED (16,11) Hamming engine; next generation of the program-1 encoder.
- Adds a decode/correct mode, a parametrised message count and base addresses, and error-statistic counters.
- Sits beside the core and masters the byte-wide data memory (dm1) port while busy; the core starts it with `req` and waits on `done`.

Parameters:
- NUM_MSG, 15, number of 16-bit messages processed per request (1..127).
- SRC_BASE, 0, byte address of the first source message (little-endian byte pair).
- DST_BASE, 30, byte address of the first result (little-endian byte pair).
- ADDR_W, 8, data-memory address width.
- CNT_W, 8, width of the error counters.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start pulse, sampled in IDLE only.
- mode  in  1  0 = encode, 1 = decode/correct; latched when req is accepted.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_rd_data  in  8  combinational read data for mem_addr.
- mem_wr_en  out  1  write strobe; memory writes on the rising edge.
- mem_wr_data  out  8  write data.
- done  out  1  high from completion until the next accepted req.
- busy  out  1  high in any non-IDLE/DONE state.
- err1_cnt  out  CNT_W  decode: single-error corrections this run.
- err2_cnt  out  CNT_W  decode: double errors detected this run.

Behaviour:
- Reset (async, reset=0): state IDLE; done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counters=0, message index=0. Reset mid-run aborts with no further writes.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE/DONE + req=1 → RD_LO. On this transition: latch mode, clear index, counters and done.
  - RD_LO: addr = SRC_BASE+2i; capture lo byte.
  - RD_HI: addr = SRC_BASE+2i+1; capture hi byte.
  - WR_LO: addr = DST_BASE+2i; wr_en=1; write result lo byte.
  - WR_HI: addr = DST_BASE+2i+1; wr_en=1; write result hi byte. Then, if i==NUM_MSG-1 → DONE, else i++ and → RD_LO.
- Timing: exactly 4 cycles per message. done rises 4*NUM_MSG+1 edges after the edge that accepts req.
- req outside IDLE/DONE is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- Encode, source format: hi = {5'b0, d[11:9]}, lo = d[8:1]; hi[7:3] are ignored.
  - Codeword bit n = Hamming position n.
  - Data positions: d1→3; d2..d4→5..7; d5..d11→9..15.
  - Parity: p1→1, p2→2, p4→4, p8→8; each p_k = XOR of data at positions with bit k set.
  - p0→0 = XOR of all 15 other bits.
  - Result: hi = {d11..d5, p8}, lo = {d4, d3, d2, p4, d1, p2, p1, p0}.
- Decode, source is a 16-bit codeword.
  - s = XOR of indices of set bits 1..15; q = XOR of all 16 bits.
  - s=0, q=0: F=00, no change.
  - q=1: F=01. Flip bit s (s=0 means p0 flipped; data unaffected). err1_cnt++.
  - s≠0, q=0: F=10. Data extracted uncorrected. err2_cnt++.
  - Result: hi = {F, 3'b000, d[11:9]}, lo = d[8:1].
- Counters saturate at all-ones; they are unused (stay 0) in encode mode.
- Result bytes are computed combinationally from the captured bytes; no extra latency.

Test Plan:
- Encode d=11'h001 (src lo=0x01, hi=0x00) → dst lo=0x0F, hi=0x00.
- Encode d=11'h7FF (lo=0xFF, hi=0x07) → dst 0xFF/0xFF. done rises exactly 61 edges after the req edge with NUM_MSG=15 (random data, all 15 match a bench model).
- Decode 0xFFFF → lo=0xFF, hi=0x07, counters 0. Decode 0xFFFE → lo=0xFF, hi=0x47, err1_cnt=1.
- Decode 0x800F (bit 15 flipped from 0x000F) → lo=0x01, hi=0x40. Decode 0xC00F (bits 15 and 14 flipped) → lo=0x01, hi=0x86, err2_cnt=1.
- Reset low mid-run (after message 3's WR_LO) → outputs at reset values immediately, no further writes; next req reruns from message 0, counters cleared.
- req pulsed while busy → ignored, no restart. req during DONE → done drops next edge and a new run starts with the newly latched mode.

Source files
------------

// File: rtl/hamming_secded_engine_if.sv
// hamming_secded_engine_if
// Groups the start/status handshake and the byte-wide data-memory port of the
// SECDED engine.
//   master modport (engine side):
//     in : req, mode, mem_rd_data
//     out: mem_addr, mem_wr_en, mem_wr_data, done, busy, err1_cnt, err2_cnt
//   slave modport (core + memory side): the same signals, opposite direction.
interface hamming_secded_engine_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              req;
    logic              mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              done;
    logic              busy;
    logic [CNT_W-1:0]  err1_cnt;
    logic [CNT_W-1:0]  err2_cnt;

    modport master (
        input  req, mode, mem_rd_data,
        output mem_addr, mem_wr_en, mem_wr_data, done, busy, err1_cnt, err2_cnt
    );

    modport slave (
        output req, mode, mem_rd_data,
        input  mem_addr, mem_wr_en, mem_wr_data, done, busy, err1_cnt, err2_cnt
    );
endinterface

// File: rtl/hamming_secded_engine.sv
// hamming_secded_engine
// Memory-mastering SECDED (16,11) Hamming engine. On an accepted req it walks
// NUM_MSG little-endian 16-bit messages from SRC_BASE, encodes (mode=0) or
// decodes/corrects (mode=1) each one, and writes the result pair to DST_BASE.
// Four cycles per message: read lo, read hi, write lo, write hi.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - hamming_secded_engine_if.master: req/mode in, done/busy/error
//           counters out, byte-wide memory port (combinational read data,
//           write on rising edge)
module hamming_secded_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    hamming_secded_engine_if.master   bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] WR_LO = 3'd3;
    localparam logic [2:0] WR_HI = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Codeword positions whose index has bit k set, for k = 0..3 (k=0 in the
    // low slice). Used both to build parity and to form the syndrome.
    localparam logic [63:0] POS_MASKS = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};

    logic [2:0]       state_reg;
    logic             mode_reg;
    logic [6:0]       idx_reg;
    logic [7:0]       lo_reg;
    logic [7:0]       hi_reg;
    logic             done_reg;
    logic [CNT_W-1:0] err1_reg;
    logic [CNT_W-1:0] err2_reg;

    // ---------------- encode path ----------------
    logic [10:0] enc_src;
    logic [15:0] enc_data;
    logic [3:0]  par;
    logic [15:0] enc_body;
    logic [15:0] enc_word;

    assign enc_src  = {hi_reg[2:0], lo_reg};
    // Data bits dropped into the non-power-of-two positions, parity slots zero.
    assign enc_data = {enc_src[10:4], 1'b0, enc_src[3:1], 1'b0, enc_src[0], 3'b000};
    assign enc_body = enc_data | {7'b0, par[3], 3'b0, par[2], 1'b0, par[1], par[0], 1'b0};
    // Overall parity in bit 0 makes the full 16-bit word even.
    assign enc_word = {enc_body[15:1], ^enc_body[15:1]};

    // ---------------- decode path ----------------
    logic [15:0] cw;
    logic [3:0]  syn;
    logic        q;
    logic [1:0]  flag;
    logic [15:0] fixed;
    logic [10:0] dec_d;
    logic [15:0] dec_word;

    assign cw = {hi_reg, lo_reg};
    assign q  = ^cw;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_syn
            assign par[gi] = ^(enc_data & POS_MASKS[gi*16 +: 16]);
            assign syn[gi] = ^(cw & POS_MASKS[gi*16 +: 16]);
        end
    endgenerate

    always_comb begin
        flag  = 2'b00;
        fixed = cw;
        if (q) begin
            // Odd overall parity: single error at position syn (0 = p0 itself).
            flag  = 2'b01;
            fixed = cw ^ (16'd1 << syn);
        end else if (syn != 4'd0) begin
            // Even parity with a nonzero syndrome: uncorrectable double error.
            flag = 2'b10;
        end
        dec_d    = {fixed[15:9], fixed[7:5], fixed[3]};
        dec_word = {flag, 3'b000, dec_d};
    end

    logic [15:0] res_word;
    assign res_word = mode_reg ? dec_word : enc_word;

    // ---------------- memory port ----------------
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;

    assign src_addr = ADDR_W'(SRC_BASE) + ADDR_W'({idx_reg, 1'b0});
    assign dst_addr = ADDR_W'(DST_BASE) + ADDR_W'({idx_reg, 1'b0});

    // Outputs decoded from state so reset forces them to zero immediately.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'h00;
        case (state_reg)
            RD_LO: bus.mem_addr = src_addr;
            RD_HI: bus.mem_addr = src_addr + ADDR_W'(1);
            WR_LO: begin
                bus.mem_addr    = dst_addr;
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = res_word[7:0];
            end
            WR_HI: begin
                bus.mem_addr    = dst_addr + ADDR_W'(1);
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = res_word[15:8];
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state_reg != IDLE) && (state_reg != DONE);
    assign bus.done     = done_reg;
    assign bus.err1_cnt = err1_reg;
    assign bus.err2_cnt = err2_reg;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            idx_reg   <= '0;
            lo_reg    <= 8'h00;
            hi_reg    <= 8'h00;
            done_reg  <= 1'b0;
            err1_reg  <= '0;
            err2_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.req) begin
                        state_reg <= RD_LO;
                        mode_reg  <= bus.mode;
                        idx_reg   <= '0;
                        done_reg  <= 1'b0;
                        err1_reg  <= '0;
                        err2_reg  <= '0;
                    end else if (state_reg == DONE) begin
                        // done is registered off DONE, rising one edge after entry.
                        done_reg <= 1'b1;
                    end
                end
                RD_LO: begin
                    lo_reg    <= bus.mem_rd_data;
                    state_reg <= RD_HI;
                end
                RD_HI: begin
                    hi_reg    <= bus.mem_rd_data;
                    state_reg <= WR_LO;
                end
                WR_LO: state_reg <= WR_HI;
                WR_HI: begin
                    if (mode_reg) begin
                        if (flag == 2'b01 && err1_reg != '1)
                            err1_reg <= err1_reg + CNT_W'(1);
                        if (flag == 2'b10 && err2_reg != '1)
                            err2_reg <= err2_reg + CNT_W'(1);
                    end
                    if (idx_reg == 7'(NUM_MSG - 1)) begin
                        state_reg <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + 7'd1;
                        state_reg <= RD_LO;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
